// File: rtl/rgb_reader_pkg.sv
// Shared types and constants for the packed-RGB SRAM reader.
package rgb_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } rgb_reader_state_t;

  localparam int WORDS_PER_GROUP = 3;
  localparam int PIX_PER_GROUP   = 2;
  localparam int SRAM_RD_LATENCY = 2;

  typedef struct packed {
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;
  } rgb_pixel_t;

endpackage

// File: rtl/rgb_pixel_fifo.sv
// Small synchronous pixel FIFO; head is shown combinationally so it stays put while not popped.
module rgb_pixel_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     Clock_50,
  input  logic                     Reset,
  input  logic                     push,
  input  logic [23:0]              push_data,
  input  logic                     pop,
  output logic [23:0]              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

endmodule

// File: rtl/rgb_sram_reader.sv
// Streams a frame of packed RGB pixel pairs out of SRAM over a valid/ready port.
// Optional Checksum port enabled by defining RGB_READER_CHECKSUM_EN.
module rgb_sram_reader
  import rgb_reader_pkg::*;
#(
  parameter logic [17:0] BASE_ADDR  = 18'd146944,
  parameter int          NUM_PIXELS = 76800,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        Pix_valid,
  input  logic        Pix_ready,
  output logic [7:0]  Pix_R,
  output logic [7:0]  Pix_G,
  output logic [7:0]  Pix_B
`ifdef RGB_READER_CHECKSUM_EN
  ,
  output logic [15:0] Checksum
`endif
);

  localparam int TOTAL_WORDS = NUM_PIXELS / PIX_PER_GROUP * WORDS_PER_GROUP;
  localparam int WCW = $clog2(TOTAL_WORDS);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(TOTAL_WORDS - 1);

  rgb_reader_state_t state, next_state;

  logic [WCW-1:0] word_cnt;
  logic [1:0]     grp_sel;
  logic [CW-1:0]  in_flight;
  logic [CW-1:0]  in_flight_next;
  logic [SRAM_RD_LATENCY-1:0] pipe_valid;
  logic [1:0]     pipe_sel [SRAM_RD_LATENCY];
  logic [15:0]    first_word;
  logic [7:0]     odd_red;

  logic           group_ok, group_start, issue, last_issue;
  logic           arr_valid;
  logic [1:0]     arr_sel;
  logic           fifo_push, fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  rgb_pixel_t     push_pix, head_pix;

  // A new group needs room for both of its pixels after everything already in flight lands.
  assign group_ok    = !fifo_full &&
                       ((int'(fifo_count) + int'(in_flight) + PIX_PER_GROUP) <= FIFO_DEPTH);
  assign issue       = (state == S_FETCH) && ((grp_sel != 2'd0) || group_ok);
  assign group_start = issue && (grp_sel == 2'd0);
  assign last_issue  = issue && (word_cnt == LAST_WORD);

  assign arr_valid = pipe_valid[SRAM_RD_LATENCY-1];
  assign arr_sel   = pipe_sel[SRAM_RD_LATENCY-1];

  always_comb begin
    fifo_push = 1'b0;
    push_pix  = '0;
    if (arr_valid && arr_sel == 2'd1) begin
      fifo_push = 1'b1;
      push_pix  = '{R: first_word[15:8], G: first_word[7:0], B: SRAM_read_data[15:8]};
    end else if (arr_valid && arr_sel == 2'd2) begin
      fifo_push = 1'b1;
      push_pix  = '{R: odd_red, G: SRAM_read_data[15:8], B: SRAM_read_data[7:0]};
    end
  end

  always_comb begin
    in_flight_next = in_flight;
    if (group_start) in_flight_next = in_flight_next + CW'(PIX_PER_GROUP);
    if (fifo_push)   in_flight_next = in_flight_next - CW'(1);
  end

  always_ff @(posedge Clock_50) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (Start) next_state = S_FETCH;
      S_FETCH: if (last_issue) next_state = S_DRAIN;
      S_DRAIN: if (pipe_valid == '0 && in_flight == '0 && fifo_empty) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == S_FETCH) || (state == S_DRAIN);
    Done = (state == S_DONE);
  end

  // The address parks on the last word of the frame instead of wrapping past 18'h3FFFF.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      SRAM_address <= BASE_ADDR;
      word_cnt     <= '0;
      grp_sel      <= '0;
      in_flight    <= '0;
      pipe_valid   <= '0;
      for (int i = 0; i < SRAM_RD_LATENCY; i++) pipe_sel[i] <= '0;
      first_word   <= '0;
      odd_red      <= '0;
    end else begin
      if (state == S_IDLE && Start) begin
        SRAM_address <= BASE_ADDR;
        word_cnt     <= '0;
        grp_sel      <= '0;
      end else if (issue) begin
        if (!last_issue) begin
          SRAM_address <= SRAM_address + 18'd1;
          word_cnt     <= word_cnt + 1'b1;
        end
        grp_sel <= (grp_sel == 2'd2) ? 2'd0 : grp_sel + 2'd1;
      end
      in_flight     <= in_flight_next;
      pipe_valid[0] <= issue;
      pipe_sel[0]   <= grp_sel;
      for (int i = 1; i < SRAM_RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_sel[i]   <= pipe_sel[i-1];
      end
      if (arr_valid && arr_sel == 2'd0) first_word <= SRAM_read_data;
      if (arr_valid && arr_sel == 2'd1) odd_red    <= SRAM_read_data[7:0];
    end
  end

`ifdef RGB_READER_CHECKSUM_EN
  always_ff @(posedge Clock_50) begin
    if (Reset)                      Checksum <= '0;
    else if (state == S_IDLE && Start) Checksum <= '0;
    else if (arr_valid)             Checksum <= Checksum + SRAM_read_data;
  end
`endif

  rgb_pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .Clock_50  (Clock_50),
    .Reset     (Reset),
    .push      (fifo_push),
    .push_data (push_pix),
    .pop       (Pix_ready),
    .head      (head_pix),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign SRAM_we_n = 1'b1;
  assign Pix_valid = !fifo_empty;
  assign Pix_R     = head_pix.R;
  assign Pix_G     = head_pix.G;
  assign Pix_B     = head_pix.B;

endmodule

// File: tb/tb_rgb_sram_reader.sv
// Directed bench for rgb_sram_reader; a short frame placed so its last word lands on 18'h3FFFF.
`timescale 1ns/1ps
module tb_rgb_sram_reader;

  localparam int NP    = 200;
  localparam int NW    = NP * 3 / 2;
  localparam int DEPTH = 4;
  localparam logic [17:0] BASE = 18'(262144 - NW);

  logic        Clock_50 = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Busy, Done, SRAM_we_n, Pix_valid;
  logic        Pix_ready = 1'b0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic [7:0]  Pix_R, Pix_G, Pix_B;
`ifdef RGB_READER_CHECKSUM_EN
  logic [15:0] Checksum;
`endif

  always #5 Clock_50 = ~Clock_50;

  rgb_sram_reader #(
    .BASE_ADDR (BASE),
    .NUM_PIXELS(NP),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .Clock_50      (Clock_50),
    .Reset         (Reset),
    .Start         (Start),
    .Busy          (Busy),
    .Done          (Done),
    .SRAM_address  (SRAM_address),
    .SRAM_we_n     (SRAM_we_n),
    .SRAM_read_data(SRAM_read_data),
    .Pix_valid     (Pix_valid),
    .Pix_ready     (Pix_ready),
    .Pix_R         (Pix_R),
    .Pix_G         (Pix_G),
    .Pix_B         (Pix_B)
`ifdef RGB_READER_CHECKSUM_EN
    ,
    .Checksum      (Checksum)
`endif
  );

  // SRAM model with a fixed two-cycle read latency
  logic [15:0] sram [0:262143];
  logic [17:0] rd_addr_q;
  always @(posedge Clock_50) begin
    rd_addr_q      <= SRAM_address;
    SRAM_read_data <= sram[rd_addr_q];
  end

  int checks = 0;
  int passed = 0;

  logic        mon_en = 1'b0;
  logic [23:0] got [$];
  int          done_cnt, stall_bad, addr_zero, fifo_over;
  logic [17:0] max_addr;
  logic        prev_stall;
  logic [23:0] prev_pix;

  always @(negedge Clock_50) begin
    if (mon_en) begin
      if (Pix_valid && Pix_ready) got.push_back({Pix_R, Pix_G, Pix_B});
      if (Done) done_cnt++;
      if (prev_stall && (!Pix_valid || {Pix_R, Pix_G, Pix_B} !== prev_pix)) stall_bad++;
      prev_stall = Pix_valid && !Pix_ready;
      prev_pix   = {Pix_R, Pix_G, Pix_B};
      if (SRAM_address == 18'd0) addr_zero++;
      if (SRAM_address > max_addr) max_addr = SRAM_address;
      if (dut.u_fifo.count > 3'(DEPTH)) fifo_over++;
    end
  end

  bit          frame_finished;
  logic [17:0] snap_addr;
  logic [2:0]  snap_count;
  logic        snap_valid, start_busy;
  logic [23:0] snap_pix;
  int          snap_got;
  logic        rst_busy, rst_done, rst_valid;
  logic [23:0] rst_pix;
  logic [17:0] rst_addr;

  function automatic logic [23:0] exp_pix(input int p);
    int a;
    logic [15:0] w0, w1, w2;
    a  = int'(BASE) + 3 * (p / 2);
    w0 = sram[a];
    w1 = sram[a+1];
    w2 = sram[a+2];
    if (p % 2 == 0) return {w0, w1[15:8]};
    return {w1[7:0], w2};
  endfunction

  function automatic int seq_errors();
    int e = 0;
    for (int p = 0; p < got.size() && p < NP; p++)
      if (got[p] !== exp_pix(p)) e++;
    return e;
  endfunction

  function automatic logic ready_val(input int cyc, input int mode, input int stall);
    if (cyc < stall) return 1'b0;
    if (mode == 1) return ($urandom_range(0, 99) < 30);
    return 1'b1;
  endfunction

  // Runs one frame: mode 0 ready=1, mode 1 random 30% ready; optional initial stall,
  // extra Start at a given cycle, or a Reset once reset_at pixels have transferred.
  task automatic run_frame(input int mode, input int stall, input int extra_start,
                           input int reset_at, input int max_cycles);
    got.delete();
    done_cnt = 0; stall_bad = 0; addr_zero = 0; fifo_over = 0;
    max_addr = '0; prev_stall = 1'b0; frame_finished = 0;
    @(posedge Clock_50); #1;
    Start = 1'b1;
    Pix_ready = ready_val(0, mode, stall);
    mon_en = 1'b1;
    for (int cyc = 1; cyc <= max_cycles; cyc++) begin
      @(posedge Clock_50); #1;
      Start = (cyc == extra_start);
      if (cyc == extra_start) start_busy = Busy;
      if (cyc == stall) begin
        snap_addr  = SRAM_address;
        snap_count = dut.u_fifo.count;
        snap_valid = Pix_valid;
        snap_pix   = {Pix_R, Pix_G, Pix_B};
        snap_got   = got.size();
      end
      Pix_ready = ready_val(cyc, mode, stall);
      if (reset_at > 0 && got.size() >= reset_at) begin
        Reset = 1'b1;
        @(posedge Clock_50); #1;
        rst_busy  = Busy;
        rst_done  = Done;
        rst_valid = Pix_valid;
        rst_pix   = {Pix_R, Pix_G, Pix_B};
        rst_addr  = SRAM_address;
        Reset  = 1'b0;
        Start  = 1'b0;
        mon_en = 1'b0;
        return;
      end
      if (done_cnt > 0) begin
        frame_finished = 1;
        break;
      end
    end
    Start = 1'b0;
    if (!frame_finished) $display("[TB] frame did not complete within %0d cycles", max_cycles);
    Pix_ready = 1'b1;
    repeat (10) @(posedge Clock_50);
    #1;
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Pix_ready = 1'b0;
    repeat (3) @(posedge Clock_50);
    #1;
    checks++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else passed++;
    checks++; if (Done !== 1'b0) $display("FAIL reset_done: got %b want 0", Done); else passed++;
    checks++; if (Pix_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", Pix_valid); else passed++;
    checks++; if ({Pix_R, Pix_G, Pix_B} !== 24'h0) $display("FAIL reset_pix: got %h want 000000", {Pix_R, Pix_G, Pix_B}); else passed++;
    checks++; if (SRAM_address !== BASE) $display("FAIL reset_addr: got %h want %h", SRAM_address, BASE); else passed++;
    checks++; if (SRAM_we_n !== 1'b1) $display("FAIL reset_we_n: got %b want 1", SRAM_we_n); else passed++;
`ifdef RGB_READER_CHECKSUM_EN
    checks++; if (Checksum !== 16'h0) $display("FAIL reset_checksum: got %h want 0000", Checksum); else passed++;
`endif
    Reset = 1'b0;
    @(posedge Clock_50); #1;
  endtask

  task automatic test_basic_stream();
    sram[BASE]   = 16'h1122;
    sram[BASE+1] = 16'h3344;
    sram[BASE+2] = 16'h5566;
    run_frame(0, 0, 0, 0, 2000);
    checks++; if (!frame_finished) $display("FAIL basic_timeout: got no Done want Done"); else passed++;
    checks++; if (got.size() != NP) $display("FAIL basic_count: got %0d want %0d", got.size(), NP); else passed++;
    checks++; if (got[0] !== 24'h112233) $display("FAIL basic_pix0: got %h want 112233", got[0]); else passed++;
    checks++; if (got[1] !== 24'h445566) $display("FAIL basic_pix1: got %h want 445566", got[1]); else passed++;
    checks++; if (seq_errors() != 0) $display("FAIL basic_seq: got %0d bad pixels want 0", seq_errors()); else passed++;
    checks++; if (done_cnt != 1) $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); else passed++;
    checks++; if (max_addr !== 18'h3FFFF) $display("FAIL basic_max_addr: got %h want 3ffff", max_addr); else passed++;
    checks++; if (addr_zero != 0) $display("FAIL basic_addr_zero: got %0d want 0", addr_zero); else passed++;
    checks++; if (SRAM_address !== 18'h3FFFF) $display("FAIL basic_end_addr: got %h want 3ffff", SRAM_address); else passed++;
    checks++; if (Busy !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", Busy); else passed++;
  endtask

  task automatic test_random_ready();
    run_frame(1, 0, 0, 0, 6000);
    checks++; if (!frame_finished) $display("FAIL random_timeout: got no Done want Done"); else passed++;
    checks++; if (got.size() != NP) $display("FAIL random_count: got %0d want %0d", got.size(), NP); else passed++;
    checks++; if (seq_errors() != 0) $display("FAIL random_seq: got %0d bad pixels want 0", seq_errors()); else passed++;
    checks++; if (stall_bad != 0) $display("FAIL random_stall_stable: got %0d violations want 0", stall_bad); else passed++;
    checks++; if (fifo_over != 0) $display("FAIL random_fifo_bound: got %0d overflows want 0", fifo_over); else passed++;
    checks++; if (done_cnt != 1) $display("FAIL random_done_cnt: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_stall_release();
    run_frame(0, 100, 0, 0, 3000);
    checks++; if (snap_addr !== BASE + 18'd6) $display("FAIL stall_addr: got %h want %h", snap_addr, BASE + 18'd6); else passed++;
    checks++; if (snap_count !== 3'(DEPTH)) $display("FAIL stall_fifo_count: got %0d want %0d", snap_count, DEPTH); else passed++;
    checks++; if (snap_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", snap_valid); else passed++;
    checks++; if (snap_pix !== exp_pix(0)) $display("FAIL stall_head: got %h want %h", snap_pix, exp_pix(0)); else passed++;
    checks++; if (snap_got != 0) $display("FAIL stall_no_transfer: got %0d want 0", snap_got); else passed++;
    checks++; if (got.size() != NP) $display("FAIL stall_count: got %0d want %0d", got.size(), NP); else passed++;
    checks++; if (seq_errors() != 0) $display("FAIL stall_seq: got %0d bad pixels want 0", seq_errors()); else passed++;
    checks++; if (done_cnt != 1) $display("FAIL stall_done_cnt: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    run_frame(0, 0, 0, NP / 2, 3000);
    checks++; if (rst_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", rst_busy); else passed++;
    checks++; if (rst_done !== 1'b0) $display("FAIL midrst_done: got %b want 0", rst_done); else passed++;
    checks++; if (rst_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", rst_valid); else passed++;
    checks++; if (rst_pix !== 24'h0) $display("FAIL midrst_pix: got %h want 000000", rst_pix); else passed++;
    checks++; if (rst_addr !== BASE) $display("FAIL midrst_addr: got %h want %h", rst_addr, BASE); else passed++;
    run_frame(0, 0, 0, 0, 2000);
    checks++; if (got.size() != NP) $display("FAIL midrst_count: got %0d want %0d", got.size(), NP); else passed++;
    checks++; if (seq_errors() != 0) $display("FAIL midrst_seq: got %0d bad pixels want 0", seq_errors()); else passed++;
    checks++; if (done_cnt != 1) $display("FAIL midrst_done_cnt: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_start_while_busy();
    run_frame(0, 0, 40, 0, 2000);
    checks++; if (start_busy !== 1'b1) $display("FAIL busy_start_seen: got %b want 1", start_busy); else passed++;
    checks++; if (done_cnt != 1) $display("FAIL busy_done_cnt: got %0d want 1", done_cnt); else passed++;
    checks++; if (got.size() != NP) $display("FAIL busy_count: got %0d want %0d", got.size(), NP); else passed++;
    checks++; if (seq_errors() != 0) $display("FAIL busy_seq: got %0d bad pixels want 0", seq_errors()); else passed++;
  endtask

`ifdef RGB_READER_CHECKSUM_EN
  task automatic test_checksum();
    logic [15:0] model;
    sram[BASE]   = 16'hFFFF;
    sram[BASE+1] = 16'hFFFF;
    sram[BASE+2] = 16'hFFFF;
    model = '0;
    for (int a = 0; a < NW; a++) model = model + sram[int'(BASE) + a];
    run_frame(0, 0, 0, 0, 2000);
    checks++; if (Checksum !== model) $display("FAIL checksum_value: got %h want %h", Checksum, model); else passed++;
    repeat (5) @(posedge Clock_50);
    #1;
    checks++; if (Checksum !== model) $display("FAIL checksum_stable: got %h want %h", Checksum, model); else passed++;
  endtask
`endif

  initial begin
    for (int a = 0; a < 262144; a++) sram[a] = 16'(a * 40503) ^ 16'(a >> 3);
    test_reset();
    test_basic_stream();
    test_random_ready();
    test_stall_release();
    test_reset_mid_frame();
    test_start_while_busy();
`ifdef RGB_READER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
